ibex_rf_sram_port_arbiter: RTL and testbench
============================================

# ibex_rf_sram_port_arbiter

Arbiter and write scheduler for the shared read/write port (port 2) of the dual-port SRAM that backs the integer register file. Port 1 stays a dedicated read port for operand A. This block shares port 2 between operand-B reads from ID and register write-backs. It buffers write-backs in a small FIFO, forwards pending write data to reads, and drains writes on idle cycles. It produces the single stall signal the core uses for port conflicts.

## Interface
- DataWidth, 32, register data width
- AddrWidth, 5, register address width (4 for RV32E)
- WbDepth, 2, write-buffer entries (power of two, >= 2)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rd_req_i  in  1  operand-B read request
- rd_addr_i  in  AddrWidth  operand-B register address
- rd_gnt_o  out  1  read accepted this cycle (combinational)
- rd_valid_o  out  1  read data valid (one cycle after grant)
- rd_data_o  out  DataWidth  read data
- wr_req_i  in  1  write-back request
- wr_addr_i  in  AddrWidth  write-back register address
- wr_data_i  in  DataWidth  write-back data
- wr_ready_o  out  1  write buffer can accept (registered)
- stall_o  out  1  rd_req_i & ~rd_gnt_o
- sram_addr_o  out  AddrWidth  port-2 address
- sram_web_o  out  1  port-2 write enable, active low
- sram_wdata_o  out  DataWidth  port-2 write data
- sram_rdata_i  in  DataWidth  port-2 read data, valid the cycle after address

## Operation
- Write buffer: FIFO of WbDepth {addr, data} entries with head, tail and count registers. Pointers wrap modulo WbDepth.
- Enqueue: wr_req_i & wr_ready_o & (wr_addr_i != 0). Writes to x0 are dropped. They are still handshaken, with no buffer or SRAM effect.
- wr_ready_o = (count != WbDepth). It does not depend on a same-cycle drain. A wr_req_i while wr_ready_o=0 is a protocol error; the bench asserts it never happens.
- Per-cycle port-2 arbitration, in priority order:
  1. Buffer full: drain the head. sram_web_o=0, addr/wdata from the head. Any rd_req_i is not granted.
  2. rd_req_i: grant. sram_web_o=1, sram_addr_o=rd_addr_i.
  3. Buffer non-empty: drain the head.
  4. Idle: sram_web_o=1, sram_addr_o=rd_addr_i.
- Reads of x0 are granted under the same rules and return 0.
- Forwarding at grant uses the youngest matching source, in this order:
  - same-cycle accepted write with wr_addr_i == rd_addr_i
  - youngest buffer entry with a matching address
  - SRAM
- On a forward hit, the selected data is captured into a forward register. A one-bit select register routes rd_data_o from the forward register or from sram_rdata_i in the next cycle.
- Simultaneous enqueue and drain: count is unchanged, and both pointers advance.
- A drained entry is not a forwarding source in its drain cycle if it has a matching read. That read is not granted while the buffer is full (rule 1). In rule 3 there is no read.

## Timing
- Reset values:
  - rd_gnt_o=0 (rd_req_i is low after reset), rd_valid_o=0, rd_data_o=0
  - wr_ready_o=1, stall_o follows rd_req_i
  - sram_web_o=1, sram_addr_o=rd_addr_i, sram_wdata_o=0
  - count=0, pointers=0, forward/select registers=0
- Read latency: grant in cycle N, rd_valid_o=1 and rd_data_o valid in cycle N+1, for both SRAM and forwarded data. rd_valid_o is high for exactly one cycle per grant.
- Back-to-back reads: one per cycle while the buffer is not full.
- A write is visible to reads in the same cycle it is accepted, through forwarding.
- Maximum stall per read: 1 cycle. A full buffer drains one entry, and count drops below WbDepth the next cycle.
- wr_ready_o updates the cycle after count changes.
- Reset mid-operation: pending buffered writes are discarded, and no SRAM write occurs after reset. An in-flight rd_valid_o is cleared.

## Test plan
- Reset, then write x5=0xDEADBEEF with rd_req_i=0. The next cycle shows sram_web_o=0, sram_addr_o=5, sram_wdata_o=0xDEADBEEF. A later read of x5 gives rd_valid_o=1 with 0xDEADBEEF one cycle after grant.
- Write x7=0x00001234 and read x7 in the same cycle: rd_gnt_o=1, and the next cycle rd_data_o=0x00001234 (forwarded). The SRAM write of x7 occurs on the first cycle without a read.
- Continuous rd_req_i while writing x1, x2, x3 (WbDepth=2): after two writes wr_ready_o=0 and the buffer drains x1 with stall_o=1 for exactly one cycle. wr_ready_o returns to 1, then x3 is accepted.
- Write x0=0xFFFFFFFF: no SRAM write, count stays 0. Reading x0 returns 0x00000000.
- Buffer x3=0xA then x3=0xB with reads held off (drains blocked by continuous reads of x4), then read x3: rd_data_o=0xB.
- Fill the buffer with x8 and x9, then assert rst_ni=0 for one cycle. After release sram_web_o stays 1 with no requests, wr_ready_o=1, and rd_valid_o=0.

Source files
------------

// File: rtl/ibex_rf_sram_port_arbiter.sv
// Port-2 arbiter for the register-file SRAM: shares the read/write port
// between operand-B reads and buffered write-backs, forwards pending write
// data to reads and raises a single stall on port conflicts.
module ibex_rf_sram_port_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned WbDepth   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 rd_req_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic                 rd_gnt_o,
  output logic                 rd_valid_o,
  output logic [DataWidth-1:0] rd_data_o,

  input  logic                 wr_req_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 wr_ready_o,

  output logic                 stall_o,

  output logic [AddrWidth-1:0] sram_addr_o,
  output logic                 sram_web_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned PtrW = $clog2(WbDepth);
  localparam int unsigned CntW = $clog2(WbDepth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WbDepth);

  // Write buffer storage and bookkeeping
  logic [AddrWidth-1:0] wb_addr_q [WbDepth];
  logic [DataWidth-1:0] wb_data_q [WbDepth];
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 wr_ready_q;

  // Read return path
  logic                 rd_valid_q;
  logic                 fwd_sel_q;
  logic [DataWidth-1:0] fwd_data_q;

  logic                 buf_full;
  logic                 buf_empty;
  logic                 wr_accept;
  logic                 drain;
  logic                 rd_gnt;

  logic                 buf_hit;
  logic [DataWidth-1:0] buf_hit_data;
  logic [PtrW-1:0]      scan_idx;
  logic                 fwd_hit;
  logic [DataWidth-1:0] fwd_data;

  assign buf_full  = (count_q == CntFull);
  assign buf_empty = (count_q == '0);

  // x0 writes are handshaken but never enter the buffer.
  assign wr_accept = wr_req_i & wr_ready_q & (wr_addr_i != '0);

  // A full buffer always wins so that a read stalls at most one cycle;
  // otherwise reads take the port and writes drain on idle cycles.
  assign drain  = buf_full | (~rd_req_i & ~buf_empty);
  assign rd_gnt = rd_req_i & ~buf_full;

  assign rd_gnt_o   = rd_gnt;
  assign stall_o    = rd_req_i & ~rd_gnt;
  assign wr_ready_o = wr_ready_q;

  assign sram_web_o   = ~drain;
  assign sram_addr_o  = drain ? wb_addr_q[head_q] : rd_addr_i;
  assign sram_wdata_o = drain ? wb_data_q[head_q] : '0;

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_valid_q ? (fwd_sel_q ? fwd_data_q : sram_rdata_i) : '0;

  // Scan buffered entries from oldest to youngest so the youngest match wins.
  // A granted read never coincides with a drain, so every live entry is a
  // valid forwarding source.
  always_comb begin
    buf_hit      = 1'b0;
    buf_hit_data = '0;
    scan_idx     = head_q;
    for (int i = 0; i < WbDepth; i++) begin
      scan_idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (wb_addr_q[scan_idx] == rd_addr_i)) begin
        buf_hit      = 1'b1;
        buf_hit_data = wb_data_q[scan_idx];
      end
    end
  end

  // Forwarding source priority: x0, same-cycle write, buffer, else SRAM.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rd_addr_i == '0) begin
      fwd_hit  = 1'b1;
      fwd_data = '0;
    end else if (wr_accept && (wr_addr_i == rd_addr_i)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data_i;
    end else if (buf_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = buf_hit_data;
    end
  end

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + PtrW'(1);
    end
    if (wr_accept) begin
      tail_d = tail_q + PtrW'(1);
    end
    if (wr_accept && !drain) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_accept && drain) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Buffer pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_ready_q <= (count_d != CntFull);
    end
  end

  // Buffer entry storage, written at the tail on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WbDepth; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else if (wr_accept) begin
      wb_addr_q[tail_q] <= wr_addr_i;
      wb_data_q[tail_q] <= wr_data_i;
    end
  end

  // Read response: valid one cycle after grant, data from forward reg or SRAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_gnt;
      fwd_sel_q  <= rd_gnt & fwd_hit;
      if (rd_gnt && fwd_hit) begin
        fwd_data_q <= fwd_data;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_sram_port_arbiter.sv
// Bench for ibex_rf_sram_port_arbiter: the reference keeps the architectural
// register values, a queue of pending writes and an SRAM array; reads must
// return the latest architecturally written value.
module tb_ibex_rf_sram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_gnt_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          wr_req_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o;
  logic          stall_o;
  logic [AW-1:0] sram_addr_o;
  logic          sram_web_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;

  ibex_rf_sram_port_arbiter #(.DataWidth(DW), .AddrWidth(AW), .WbDepth(D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .stall_o(stall_o),
    .sram_addr_o(sram_addr_o), .sram_web_o(sram_web_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] mem  [32];
  logic [DW-1:0] arch [32];
  logic          pend_valid;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] rdata_nxt;
  int            n_chk  = 0;
  int            n_pass = 0;

  logic          obs_gnt, obs_valid, obs_ready, obs_stall, obs_web;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rdata;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    pend_valid = 1'b0;
    pend_data  = '0;
    for (int a = 0; a < 32; a++) arch[a] = mem[a];
  endtask

  // One clock cycle: drive, compare all outputs with the reference, advance.
  task automatic step(input logic rq, input logic [AW-1:0] ra,
                      input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic          full, gnt, drn, acc;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    @(negedge clk);
    sram_rdata_i = rdata_nxt;
    rd_req_i  = rq;
    rd_addr_i = ra;
    wr_req_i  = wq;
    wr_addr_i = wa;
    wr_data_i = wd;
    #1;
    full = (q.size() == D);
    gnt  = rq && !full;
    drn  = full || (!rq && q.size() != 0);
    ea   = ra;
    ewd  = '0;
    if (drn) begin
      ea  = q[0].a;
      ewd = q[0].d;
    end
    chk("rd_gnt",     32'(rd_gnt_o),   32'(gnt));
    chk("stall",      32'(stall_o),    32'(rq && !gnt));
    chk("wr_ready",   32'(wr_ready_o), 32'(!full));
    chk("sram_web",   32'(sram_web_o), 32'(!drn));
    chk("sram_addr",  32'(sram_addr_o), 32'(ea));
    chk("sram_wdata", sram_wdata_o,    ewd);
    chk("rd_valid",   32'(rd_valid_o), 32'(pend_valid));
    chk("rd_data",    rd_data_o,       pend_valid ? pend_data : '0);
    obs_gnt = rd_gnt_o;  obs_valid = rd_valid_o; obs_ready = wr_ready_o;
    obs_stall = stall_o; obs_web = sram_web_o;   obs_addr = sram_addr_o;
    obs_wdata = sram_wdata_o; obs_rdata = rd_data_o;
    if (wq && !wr_ready_o) $display("FAIL protocol: wr_req while not ready at %0t", $time);
    // SRAM device: write on web low, otherwise registered read.
    if (!sram_web_o) begin
      mem[sram_addr_o] = sram_wdata_o;
      rdata_nxt = $urandom;
    end else begin
      rdata_nxt = mem[sram_addr_o];
    end
    acc = wq && !full && (wa != '0);
    if (acc) arch[wa] = wd;
    pend_valid = gnt;
    pend_data  = (ra == '0) ? '0 : arch[ra];
    if (drn) void'(q.pop_front());
    if (acc) q.push_back('{a: wa, d: wd});
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic flush();
    for (int k = 0; k < 2 * D + 2; k++) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd_req_i = 1'b0; wr_req_i = 1'b0; rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data",  rd_data_o,       32'd0);
    chk("rst_web",      32'(sram_web_o), 32'd1);
    chk("rst_ready",    32'(wr_ready_o), 32'd1);
    chk("rst_wdata",    sram_wdata_o,    32'd0);
    chk("rst_stall",    32'(stall_o),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 5));
  endfunction

  initial begin
    rst_n = 1'b0;
    rd_req_i = 1'b0; rd_addr_i = '0; wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    sram_rdata_i = '0;
    rdata_nxt = '0;
    for (int a = 0; a < 32; a++) mem[a] = $urandom;
    mem[0] = 32'hFFFF_FFFF;
    do_reset();

    // Write x5 with no read, drain next cycle, read back from SRAM.
    step(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("t1_web_idle", 32'(obs_web), 32'd1);
    idle();
    chk("t1_drain_web",   32'(obs_web), 32'd0);
    chk("t1_drain_addr",  32'(obs_addr), 32'd5);
    chk("t1_drain_wdata", obs_wdata, 32'hDEAD_BEEF);
    step(1'b1, 5'd5, 1'b0, '0, '0);
    idle();
    chk("t1_rd_valid", 32'(obs_valid), 32'd1);
    chk("t1_rd_data",  obs_rdata, 32'hDEAD_BEEF);

    // Same-cycle write and read of x7: forwarded.
    step(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_1234);
    chk("t2_gnt", 32'(obs_gnt), 32'd1);
    idle();
    chk("t2_rd_data", obs_rdata, 32'h0000_1234);
    chk("t2_web",     32'(obs_web), 32'd0);
    chk("t2_addr",    32'(obs_addr), 32'd7);
    flush();

    // Continuous reads while writing x1, x2, x3.
    step(1'b1, 5'd10, 1'b1, 5'd1, 32'hA1);
    step(1'b1, 5'd11, 1'b1, 5'd2, 32'hA2);
    step(1'b1, 5'd12, 1'b0, '0, '0);
    chk("t3_stall_full", 32'(obs_stall), 32'd1);
    chk("t3_ready_full", 32'(obs_ready), 32'd0);
    chk("t3_drain_addr", 32'(obs_addr), 32'd1);
    step(1'b1, 5'd13, 1'b0, '0, '0);
    chk("t3_stall_after", 32'(obs_stall), 32'd0);
    chk("t3_ready_after", 32'(obs_ready), 32'd1);
    step(1'b1, 5'd14, 1'b1, 5'd3, 32'hA3);
    chk("t3_gnt_x3", 32'(obs_gnt), 32'd1);
    flush();

    // x0 write dropped, x0 read returns zero.
    step(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle();
    chk("t4_no_write", 32'(obs_web), 32'd1);
    step(1'b1, 5'd0, 1'b0, '0, '0);
    idle();
    chk("t4_rd_x0", obs_rdata, 32'h0);

    // Two writes of x3 buffered behind reads of x4, then read x3.
    step(1'b1, 5'd4, 1'b1, 5'd3, 32'hA);
    step(1'b1, 5'd4, 1'b1, 5'd3, 32'hB);
    step(1'b1, 5'd3, 1'b0, '0, '0);
    step(1'b1, 5'd3, 1'b0, '0, '0);
    idle();
    chk("t5_youngest", obs_rdata, 32'hB);
    flush();

    // Fill with x8, x9 then reset: buffered writes discarded.
    step(1'b0, 5'd0, 1'b1, 5'd8, 32'h8888_8888);
    step(1'b1, 5'd4, 1'b1, 5'd9, 32'h9999_9999);
    do_reset();
    idle();
    chk("t6_web",   32'(obs_web), 32'd1);
    chk("t6_ready", 32'(obs_ready), 32'd1);
    chk("t6_valid", 32'(obs_valid), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, pick(),
             (q.size() != D) && ($urandom_range(0, 1) == 1), pick(), $urandom);
      end
    end
    flush();
    for (int a = 1; a < 32; a++) chk("sram_final", mem[a], arch[a]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
